// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: RV32I load/store funct3 codes,
// error-cause codes, FSM state encoding and legality/alignment helpers.
package mem_access_stage_pkg;

    // Load encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Error causes reported on mem_err_cause_o
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Stores only have byte/half/word; loads add the unsigned byte/half forms.
    function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        if (is_store)
            ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        else
            ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                 (f3 == F3_LBU) || (f3 == F3_LHU);
        return ok;
    endfunction

    // Access size is carried in funct3[1:0] for both loads and stores.
    function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] lo);
        logic ok;
        case (f3[1:0])
            2'b01:   ok = ~lo[0];
            2'b10:   ok = (lo == 2'b00);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and lane extraction / extension for loads.
// Purely combinational so it can be shared with a future cache front end.
module mem_lane_align
    import mem_access_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    function automatic logic [31:0] sext8(input logic [7:0] b);
        logic signed [7:0] sb;
        sb = signed'(b);
        return 32'(sb);
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] h);
        logic signed [15:0] sh;
        sh = signed'(h);
        return 32'(sh);
    endfunction

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Select the addressed byte and halfword out of the returned word
    always_comb begin
        lane_byte = rdata[{addr_lo, 3'b000} +: 8];
        lane_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // Store steering: replicate the datum so every enabled lane carries it
    always_comb begin
        be    = 4'b1111;
        wdata = store_data;
        case (funct3[1:0])
            F3_SB[1:0]: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            F3_SH[1:0]: begin
                be    = 4'b0011 << addr_lo;
                wdata = {2{store_data[15:0]}};
            end
            F3_SW[1:0]: begin
                be    = 4'b1111;
                wdata = store_data;
            end
            default: ;
        endcase
    end

    // Load extraction with sign or zero extension
    always_comb begin
        case (funct3)
            F3_LB:   load_data = sext8(lane_byte);
            F3_LH:   load_data = sext16(lane_half);
            F3_LBU:  load_data = {24'h0, lane_byte};
            F3_LHU:  load_data = {16'h0, lane_half};
            F3_LW:   load_data = rdata;
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage. Non-memory instructions pass straight through to the
// MEM/WB register in the same cycle; loads and stores are accepted in IDLE,
// then held in BUSY until the data memory answers or the bus times out.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] store_data_i,
    input  logic        reg_write_i,
    input  logic [4:0]  reg_write_data_addr_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ready_i,
    input  logic [31:0] dmem_rdata_i,
    output logic [31:0] reg_write_data_o,
    output logic        reg_write_o,
    output logic [4:0]  reg_write_data_addr_o,
    output logic        stall_o,
    output logic        mem_err_o,
    output logic [1:0]  mem_err_cause_o
);

    state_t state, state_next;
    logic [CNT_W-1:0] cnt;

    // Request fields captured on accept and replayed for the whole BUSY period
    logic [31:0] addr_p1;
    logic [2:0]  f3_p1;
    logic        we_p1;
    logic [3:0]  be_p1;
    logic [31:0] wdata_p1;
    logic [4:0]  rd_p1;
    logic        rw_p1;

    logic mem_op, f3_ok, aligned, accept, cnt_last;

    logic [2:0]  align_f3;
    logic [1:0]  align_lo;
    logic [3:0]  align_be;
    logic [31:0] align_wdata, align_load;

    logic        req, we, wb_en, stall, err;
    logic [31:0] addr_out, wdata_out, wb_data;
    logic [3:0]  be_out;
    logic [4:0]  wb_rd;
    logic [1:0]  err_cause;

    assign mem_op   = valid_i & (mem_read_i | mem_write_i);
    assign f3_ok    = funct3_legal(mem_write_i, funct3_i);
    assign aligned  = addr_aligned(funct3_i, alu_result_i[1:0]);
    assign accept   = (state == ST_IDLE) & mem_op & f3_ok & aligned;
    assign cnt_last = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // In IDLE the aligner steers the incoming store; in BUSY it extracts the load
    assign align_f3 = (state == ST_BUSY) ? f3_p1 : funct3_i;
    assign align_lo = (state == ST_BUSY) ? addr_p1[1:0] : alu_result_i[1:0];

    mem_lane_align u_align (
        .funct3     (align_f3),
        .addr_lo    (align_lo),
        .store_data (store_data_i),
        .rdata      (dmem_rdata_i),
        .be         (align_be),
        .wdata      (align_wdata),
        .load_data  (align_load)
    );

    // FSM state register and bus-timeout counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state == ST_BUSY && !dmem_ready_i && !cnt_last)
                cnt <= cnt + 1'b1;
            else
                cnt <= '0;
        end
    end

    // Capture the request when a legal, aligned memory op is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_p1  <= '0;
            f3_p1    <= '0;
            we_p1    <= 1'b0;
            be_p1    <= '0;
            wdata_p1 <= '0;
            rd_p1    <= '0;
            rw_p1    <= 1'b0;
        end else if (accept) begin
            addr_p1  <= alu_result_i;
            f3_p1    <= funct3_i;
            we_p1    <= mem_write_i;
            be_p1    <= align_be;
            wdata_p1 <= align_wdata;
            rd_p1    <= reg_write_data_addr_i;
            rw_p1    <= reg_write_i;
        end
    end

    // Next state, memory request, write-back, stall and error generation
    always_comb begin
        state_next = state;
        req        = 1'b0;
        we         = 1'b0;
        addr_out   = '0;
        be_out     = '0;
        wdata_out  = '0;
        wb_data    = alu_result_i;
        wb_en      = 1'b0;
        wb_rd      = reg_write_data_addr_i;
        stall      = 1'b0;
        err        = 1'b0;
        err_cause  = 2'b00;
        if (state == ST_IDLE) begin
            if (!mem_op) begin
                wb_en = valid_i & reg_write_i;
            end else if (!f3_ok) begin
                err       = 1'b1;
                err_cause = CAUSE_ILLEGAL;
            end else if (!aligned) begin
                err       = 1'b1;
                err_cause = CAUSE_MISALIGN;
            end else begin
                stall      = 1'b1;
                state_next = ST_BUSY;
            end
        end else begin
            req       = 1'b1;
            we        = we_p1;
            addr_out  = {addr_p1[31:2], 2'b00};
            be_out    = be_p1;
            wdata_out = wdata_p1;
            wb_rd     = rd_p1;
            wb_data   = align_load;
            if (dmem_ready_i) begin
                state_next = ST_IDLE;
                wb_en      = rw_p1 & ~we_p1;
            end else if (cnt_last) begin
                state_next = ST_IDLE;
                err        = 1'b1;
                err_cause  = CAUSE_TIMEOUT;
            end else begin
                stall = 1'b1;
            end
        end
    end

    // Everything is forced low while reset is held, including the pass-through path
    assign dmem_req_o            = rst_n & req;
    assign dmem_we_o             = rst_n & we;
    assign dmem_addr_o           = rst_n ? addr_out : '0;
    assign dmem_be_o             = rst_n ? be_out : '0;
    assign dmem_wdata_o          = rst_n ? wdata_out : '0;
    assign reg_write_data_o      = rst_n ? wb_data : '0;
    assign reg_write_o           = rst_n & wb_en;
    assign reg_write_data_addr_o = rst_n ? wb_rd : '0;
    assign stall_o               = rst_n & stall;
    assign mem_err_o             = rst_n & err;
    assign mem_err_cause_o       = rst_n ? err_cause : '0;

endmodule
